// File: rtl/log_pkg.sv
// Shared definitions for the access-log reader: entry layout, field bounds,
// the dump FSM state encoding (also referenced by simulation monitors), and
// the byte-select helper used to serialise an entry MSB first.
package log_pkg;

    localparam int unsigned LOG_ENTRY_W  = 24;
    localparam int unsigned LOG_TYPE_MSB = 23;
    localparam int unsigned LOG_TYPE_LSB = 16;
    localparam int unsigned LOG_ADDR_MSB = 15;
    localparam int unsigned LOG_ADDR_LSB = 0;

    typedef struct packed {
        logic [LOG_TYPE_MSB-LOG_TYPE_LSB:0] typ;
        logic [LOG_ADDR_MSB-LOG_ADDR_LSB:0] addr;
    } log_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_SEND2   = 3'd3,
        ST_SEND1   = 3'd4,
        ST_SEND0   = 3'd5,
        ST_FINISH  = 3'd6
    } log_state_e;

    // Byte presented in a given send state: type, then addr high, then addr low.
    function automatic logic [7:0] log_byte(input log_entry_t e, input log_state_e s);
        logic [7:0] b;
        case (s)
            ST_SEND2: b = e.typ;
            ST_SEND1: b = e.addr[15:8];
            default:  b = e.addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/log_dump_reader.sv
// Streams a range of access-log entries out of the log BRAM read port and
// serialises each 24-bit entry into three bytes for the UART transmitter.
// Ports:
//   clk_50, rst_n              clock, asynchronous active-low reset
//   start/start_addr/count     launch a dump of count entries from start_addr
//   abort                      cancel a running dump
//   busy/done/err              status: running, end pulse, sticky read timeout
//   log_addr/log_rd            BRAM read request
//   log_data/log_data_valid    BRAM read response
//   tx_data/tx_valid/tx_ready  byte stream towards the UART
module log_dump_reader
    import log_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic                   clk_50,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    input  logic [ADDR_WIDTH:0]    count,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ADDR_WIDTH-1:0]  log_addr,
    output logic                   log_rd,
    input  logic [LOG_ENTRY_W-1:0] log_data,
    input  logic                   log_data_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam int unsigned TMR_W = $clog2(RD_TIMEOUT + 1);

    log_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, cur_addr_d;
    logic [CNT_W-1:0]       remaining_q, remaining_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    log_entry_t             entry_q, entry_d;
    logic                   err_d;
    logic                   send_d;

    // State and datapath registers.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            timer_q     <= '0;
            entry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            timer_q     <= timer_d;
            entry_q     <= entry_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        timer_d     = timer_q;
        entry_d     = entry_q;
        err_d       = err;

        case (state_q)
            ST_IDLE: begin
                // done still high means the previous dump just ended: start ignored.
                if (start && !done) begin
                    cur_addr_d  = start_addr;
                    remaining_d = count;
                    err_d       = 1'b0;
                    state_d     = (count == '0) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                timer_d = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (log_data_valid) begin
                    entry_d = log_entry_t'(log_data);
                    state_d = ST_SEND2;
                end else if (timer_q == TMR_W'(RD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_SEND2: if (tx_valid && tx_ready) state_d = ST_SEND1;
            ST_SEND1: if (tx_valid && tx_ready) state_d = ST_SEND0;
            ST_SEND0: begin
                if (tx_valid && tx_ready) begin
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = (remaining_q == CNT_W'(1)) ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Abort overrides everything once a dump is running; FINISH is left alone
        // so a held abort cannot trap the FSM there.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_FINISH)) begin
            state_d = ST_FINISH;
        end

        send_d = (state_d == ST_SEND2) || (state_d == ST_SEND1) || (state_d == ST_SEND0);
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            log_rd   <= 1'b0;
            log_addr <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            busy     <= (state_d != ST_IDLE);
            done     <= (state_q == ST_FINISH);
            err      <= err_d;
            log_rd   <= (state_d == ST_RD_REQ);
            tx_valid <= send_d;
            if (state_d == ST_RD_REQ) begin
                log_addr <= cur_addr_d;
            end
            if (send_d) begin
                tx_data <= log_byte(entry_d, state_d);
            end
        end
    end

endmodule

// File: tb/tb_log_dump_reader.sv
// Bench for log_dump_reader: BRAM model with 1-cycle latency, reference
// queues of expected read addresses and bytes built from the log contents.
module tb_log_dump_reader;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk_50 = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          abort = 1'b0;
    logic          busy, done, err;
    logic [AW-1:0] log_addr;
    logic          log_rd;
    logic [23:0]   log_data = '0;
    logic          log_data_valid = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b1;

    log_dump_reader #(.ADDR_WIDTH(AW), .RD_TIMEOUT(15)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .count(count), .abort(abort), .busy(busy), .done(done), .err(err),
        .log_addr(log_addr), .log_rd(log_rd), .log_data(log_data),
        .log_data_valid(log_data_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial forever #10 clk_50 = ~clk_50;

    // Log contents and BRAM read port model.
    logic [23:0] mem [DEPTH];
    logic        bram_on = 1'b1;
    always @(posedge clk_50) begin
        log_data_valid <= rst_n && bram_on && log_rd;
        if (log_rd) log_data <= mem[log_addr];
    end

    // tx_ready: 0 = always ready, 1 = random 25% duty, 2 = driven by hand.
    int rdy_mode = 0;
    initial forever begin
        @(posedge clk_50);
        #1;
        if (rdy_mode == 0)      tx_ready = 1'b1;
        else if (rdy_mode == 1) tx_ready = ($urandom_range(0, 3) == 0);
    end

    int n_checks = 0;
    int n_pass   = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: expected read addresses and accepted bytes, in order.
    logic [AW-1:0] exp_addr_q [$];
    logic [7:0]    exp_byte_q [$];
    int            rd_seen   = 0;
    int            byte_seen = 0;

    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_data  = '0;

    always @(negedge clk_50) begin
        if (rst_n) begin
            if (log_rd) begin
                rd_seen++;
                check("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) check("log_addr", 32'(log_addr), 32'(exp_addr_q.pop_front()));
            end
            if (tx_valid && tx_ready) begin
                byte_seen++;
                check("byte_expected", 32'(exp_byte_q.size() != 0), 32'd1);
                if (exp_byte_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_byte_q.pop_front()));
            end
            if (prev_stall && !prev_abort) begin
                check("tx_valid_hold", 32'(tx_valid), 32'd1);
                check("tx_data_hold", 32'(tx_data), 32'(prev_data));
            end
            prev_stall <= tx_valid && !tx_ready;
            prev_abort <= abort;
            prev_data  <= tx_data;
        end else begin
            prev_stall <= 1'b0;
            prev_abort <= 1'b0;
        end
    end

    // Launch one dump, wait (bounded) for done, and check the outcome.
    task automatic run_dump(input string name, input logic [AW-1:0] sa, input logic [AW:0] cnt,
                            input int mode, input int exp_reads, input int exp_bytes,
                            input int exp_done_k, input logic exp_err);
        int k;
        int r0;
        int b0;
        int budget;
        rdy_mode = mode;
        for (int i = 0; i < exp_reads; i++) exp_addr_q.push_back(AW'((int'(sa) + i) % DEPTH));
        for (int i = 0; i < exp_bytes / 3; i++) begin
            logic [23:0] e;
            e = mem[AW'((int'(sa) + i) % DEPTH)];
            exp_byte_q.push_back(e[23:16]);
            exp_byte_q.push_back(e[15:8]);
            exp_byte_q.push_back(e[7:0]);
        end
        r0 = rd_seen;
        b0 = byte_seen;
        budget = 100 + 40 * int'(cnt);
        @(posedge clk_50);
        #1 start = 1'b1; start_addr = sa; count = cnt;
        @(posedge clk_50);
        #1 start = 1'b0;
        @(negedge clk_50);
        k = 1;
        check({name, "_busy_after_start"}, 32'(busy), 32'd1);
        check({name, "_err_cleared"}, 32'(err), 32'd0);
        while (!done && k < budget) begin
            @(negedge clk_50);
            k++;
        end
        check({name, "_done_seen"}, 32'(done), 32'd1);
        if (exp_done_k > 0) check({name, "_done_latency"}, 32'(k), 32'(exp_done_k));
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        check({name, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk_50);
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_reads"}, 32'(rd_seen - r0), 32'(exp_reads));
        check({name, "_bytes"}, 32'(byte_seen - b0), 32'(exp_bytes));
        check({name, "_left_rd"}, 32'(exp_addr_q.size()), 32'd0);
        check({name, "_left_bytes"}, 32'(exp_byte_q.size()), 32'd0);
        exp_addr_q.delete();
        exp_byte_q.delete();
        rdy_mode = 0;
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] sa;
        logic [AW:0]   cnt;
        int            mode;
        int            exp_reads;
        int            exp_bytes;
        int            exp_done_k;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int k;
        vecs[0] = '{"basic",   10'h005,    11'd2,  0,    2,    6, 0};
        vecs[1] = '{"wrap",    10'h3FF,    11'd2,  0,    2,    6, 0};
        vecs[2] = '{"count0",  10'h011,    11'd0,  0,    0,    0, 2};
        vecs[3] = '{"stall_a", 10'h123,    11'd5,  1,    5,   15, 0};
        vecs[4] = '{"stall_b", 10'h3FD,    11'd6,  1,    6,   18, 0};
        vecs[5] = '{"full",    10'h200, 11'd1024,  0, 1024, 3072, 0};

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 24'($urandom());
        mem[10'h005] = 24'hA11234;
        mem[10'h006] = 24'hB25678;

        // Reset values.
        repeat (3) @(negedge clk_50);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_log_rd", 32'(log_rd), 32'd0);
        check("rst_log_addr", 32'(log_addr), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50);

        for (int i = 0; i < 6; i++)
            run_dump(vecs[i].name, vecs[i].sa, vecs[i].cnt, vecs[i].mode,
                     vecs[i].exp_reads, vecs[i].exp_bytes, vecs[i].exp_done_k, 1'b0);

        for (int i = 0; i < 6; i++) begin
            logic [AW:0] c;
            c = (AW + 1)'($urandom_range(1, 8));
            run_dump("rand", AW'($urandom()), c, int'($urandom_range(0, 1)),
                     int'(c), 3 * int'(c), 0, 1'b0);
        end

        // Read timeout: only the first entry is requested, no bytes, err set.
        bram_on = 1'b0;
        run_dump("timeout", 10'h020, 11'd3, 0, 1, 0, 18, 1'b1);
        bram_on = 1'b1;
        repeat (3) @(negedge clk_50);
        check("err_sticky", 32'(err), 32'd1);
        run_dump("after_timeout", 10'h021, 11'd1, 0, 1, 3, 0, 1'b0);

        // Abort in IDLE has no effect.
        @(posedge clk_50);
        #1 abort = 1'b1;
        @(posedge clk_50);
        #1 abort = 1'b0;
        @(negedge clk_50);
        check("idle_abort_busy", 32'(busy), 32'd0);
        @(negedge clk_50);
        check("idle_abort_done", 32'(done), 32'd0);

        // Abort while stalled in the second byte; a start mid-dump is ignored.
        rdy_mode = 2;
        tx_ready = 1'b0;
        exp_addr_q.push_back(10'h040);
        exp_byte_q.push_back(mem[10'h040][23:16]);
        @(posedge clk_50);
        #1 start = 1'b1; start_addr = 10'h040; count = 11'd4;
        @(posedge clk_50);
        #1 start = 1'b0;
        k = 0;
        while (!tx_valid && k < 50) begin
            @(negedge clk_50);
            k++;
        end
        check("abort_first_byte_valid", 32'(tx_valid), 32'd1);
        @(posedge clk_50);
        #1 tx_ready = 1'b1;
        @(posedge clk_50);
        #1 tx_ready = 1'b0; start = 1'b1; start_addr = 10'h100; count = 11'd7;
        @(posedge clk_50);
        #1 start = 1'b0;
        @(negedge clk_50);
        check("abort_send1_valid", 32'(tx_valid), 32'd1);
        check("abort_send1_byte", 32'(tx_data), 32'(mem[10'h040][15:8]));
        @(posedge clk_50);
        #1 abort = 1'b1;
        @(posedge clk_50);
        #1 abort = 1'b0;
        @(negedge clk_50);
        check("abort_tx_valid_drop", 32'(tx_valid), 32'd0);
        check("abort_busy_finish", 32'(busy), 32'd1);
        @(negedge clk_50);
        check("abort_done", 32'(done), 32'd1);
        check("abort_busy_clear", 32'(busy), 32'd0);
        repeat (5) @(negedge clk_50);
        check("abort_no_more_rd", 32'(exp_addr_q.size()), 32'd0);
        check("abort_no_more_bytes", 32'(exp_byte_q.size()), 32'd0);
        rdy_mode = 0;
        repeat (2) @(negedge clk_50);

        // Reset mid-dump: outputs clear at once and no done pulse follows.
        for (int i = 0; i < 3; i++) begin
            logic [23:0] e;
            e = mem[10'h080 + i];
            exp_addr_q.push_back(AW'(10'h080 + i));
            exp_byte_q.push_back(e[23:16]);
            exp_byte_q.push_back(e[15:8]);
            exp_byte_q.push_back(e[7:0]);
        end
        @(posedge clk_50);
        #1 start = 1'b1; start_addr = 10'h080; count = 11'd3;
        @(posedge clk_50);
        #1 start = 1'b0;
        repeat (4) @(posedge clk_50);
        #5 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_valid", 32'(tx_valid), 32'd0);
        check("midrst_log_rd", 32'(log_rd), 32'd0);
        exp_addr_q.delete();
        exp_byte_q.delete();
        @(negedge clk_50);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_50);
            check("midrst_no_done", 32'(done), 32'd0);
        end
        run_dump("after_rst", 10'h081, 11'd2, 1, 2, 6, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
